// File: rtl/ml_result_tx_pkg.sv
// Shared definitions for the ML result streamer: FSM encoding and AXI-Stream sizing.
// Build option ML_TX_HEADER_EN (see ml_result_tx) prefixes each frame with a word-count header.
package ml_result_tx_pkg;

    localparam int AXIS_DATA_W           = 32;
    localparam int DEFAULT_NUM_OUT_WORDS = 64;
    localparam int HDR_COUNT_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/ml_result_buf.sv
// Result buffer: DEPTH x DATA_W register array with one write port and an asynchronous read port.
// Writes to addresses at or beyond DEPTH are dropped.
module ml_result_buf #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              addr_ok;

    assign addr_ok = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));

    // NOTE: the storage array has no reset; its contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (wr_en && addr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ml_result_tx.sv
// Streams a buffered frame of ML result words out over AXI-Stream on each start request.
// Define ML_TX_HEADER_EN to prefix every frame with a header beat carrying NUM_OUT_WORDS.
module ml_result_tx
    import ml_result_tx_pkg::*;
#(
    parameter int NUM_OUT_WORDS = DEFAULT_NUM_OUT_WORDS,
    parameter int DATA_W        = 8
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic                             wr_en,
    input  logic [$clog2(NUM_OUT_WORDS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             M_AXIS_TVALID,
    output logic [AXIS_DATA_W-1:0]           M_AXIS_TDATA,
    output logic                             M_AXIS_TLAST,
    input  logic                             M_AXIS_TREADY
);

    localparam int AW = $clog2(NUM_OUT_WORDS);
`ifdef ML_TX_HEADER_EN
    localparam int NUM_BEATS = NUM_OUT_WORDS + 1;
`else
    localparam int NUM_BEATS = NUM_OUT_WORDS;
`endif
    localparam int              CNT_W     = $clog2(NUM_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    tx_state_t              state, state_nxt;
    logic [CNT_W-1:0]       beat_idx, beat_idx_nxt;
    logic                   handshake;
    logic                   last_beat;
    logic [AW-1:0]          rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic [AXIS_DATA_W-1:0] beat_data;

    // Writes are locked out while a frame is streaming so the frame stays coherent.
    ml_result_buf #(
        .DEPTH  (NUM_OUT_WORDS),
        .DATA_W (DATA_W),
        .ADDR_W (AW)
    ) u_buf (
        .clk     (ACLK),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef ML_TX_HEADER_EN
    assign rd_addr   = AW'(beat_idx - CNT_W'(1));
    assign beat_data = (beat_idx == '0) ? AXIS_DATA_W'(HDR_COUNT_W'(NUM_OUT_WORDS))
                                        : AXIS_DATA_W'(rd_data);
`else
    assign rd_addr   = AW'(beat_idx);
    assign beat_data = AXIS_DATA_W'(rd_data);
`endif

    // Outputs decode directly from registered state, so reset clears them without a clock.
    assign busy          = (state == ST_SEND);
    assign done          = (state == ST_FIN);
    assign last_beat     = (beat_idx == LAST_BEAT);
    assign M_AXIS_TVALID = busy;
    assign M_AXIS_TLAST  = busy && last_beat;
    assign M_AXIS_TDATA  = busy ? beat_data : '0;
    assign handshake     = M_AXIS_TVALID && M_AXIS_TREADY;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= ST_IDLE;
            beat_idx <= '0;
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_idx_nxt;
        end
    end

    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        beat_idx_nxt = beat_idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_SEND;
                    beat_idx_nxt = '0;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (last_beat) begin
                        state_nxt    = ST_FIN;
                        beat_idx_nxt = '0;
                    end else begin
                        beat_idx_nxt = beat_idx + CNT_W'(1);
                    end
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt    = ST_IDLE;
                beat_idx_nxt = '0;
            end
        endcase
    end

endmodule
